// File: rtl/upg_word_assembler.sv
// upg_word_assembler: UART byte stream to little-endian 32-bit ROM words; UPG_TIMEOUT_EN adds an inter-byte idle timeout.
module upg_word_assembler #(
    parameter int ADDR_W         = 14,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              upg_clk_i,
    input  logic              upg_rst_i,
    input  logic [7:0]        rx_dat_i,
    input  logic              rx_vld_i,
    output logic              upg_wen_o,
    output logic [ADDR_W-1:0] upg_adr_o,
    output logic [31:0]       upg_dat_o,
    output logic              upg_done_o,
    output logic              upg_err_o
);
    typedef enum logic [2:0] {IDLE, CNT_HI, DATA, DONE, ERR} state_t;
    state_t state, state_d;
    logic [15:0] count;
    logic [1:0] byte_idx;
    logic [23:0] lanes;
    logic [ADDR_W:0] wr_cnt;
    logic timeout, bad_count, last_wr, take, fire, done_d, err_d;
`ifdef UPG_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle;
    always_ff @(posedge upg_clk_i) begin
        if (upg_rst_i || rx_vld_i || !(state == CNT_HI || state == DATA))
            idle <= '0;
        else if (idle != TW'(TIMEOUT_CYCLES))
            idle <= idle + 1'b1;
    end
    assign timeout = !rx_vld_i && idle == TW'(TIMEOUT_CYCLES);
`else
    assign timeout = TIMEOUT_CYCLES < 0;
`endif
    assign bad_count = {rx_dat_i, count[7:0]} == 16'd0 ||
                       32'({rx_dat_i, count[7:0]}) > (32'd1 << ADDR_W);
    // wr_cnt already counts the word being written during the wen cycle
    assign last_wr = upg_wen_o && 32'(wr_cnt) == 32'(count);
    assign take = state == DATA && rx_vld_i && !last_wr;
    assign fire = take && byte_idx == 2'd3;
    always_ff @(posedge upg_clk_i) begin
        if (upg_rst_i)
            state <= IDLE;
        else
            state <= state_d;
    end
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = rx_vld_i ? CNT_HI : IDLE;
            CNT_HI:  state_d = rx_vld_i ? (bad_count ? ERR : DATA) : (timeout ? ERR : CNT_HI);
            DATA:    state_d = last_wr ? DONE : (timeout ? ERR : DATA);
            default: state_d = state;
        endcase
    end
    always_comb begin
        done_d = state_d == DONE;
        err_d  = state_d == ERR;
    end
    always_ff @(posedge upg_clk_i) begin
        if (upg_rst_i) begin
            upg_wen_o  <= 1'b0;
            upg_adr_o  <= '0;
            upg_dat_o  <= '0;
            upg_done_o <= 1'b0;
            upg_err_o  <= 1'b0;
            count      <= '0;
            byte_idx   <= '0;
            lanes      <= '0;
            wr_cnt     <= '0;
        end else begin
            upg_wen_o  <= fire;
            upg_done_o <= done_d;
            upg_err_o  <= err_d;
            if (state == IDLE && rx_vld_i)
                count[7:0] <= rx_dat_i;
            if (state == CNT_HI && rx_vld_i) begin
                count[15:8] <= rx_dat_i;
                byte_idx    <= '0;
                wr_cnt      <= '0;
            end
            if (take) begin
                byte_idx <= byte_idx + 2'd1;
                lanes    <= {rx_dat_i, lanes[23:8]};
            end
            if (fire) begin
                upg_dat_o <= {rx_dat_i, lanes};
                upg_adr_o <= wr_cnt[ADDR_W-1:0];
                wr_cnt    <= wr_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_upg_word_assembler.sv
// tb_upg_word_assembler: directed byte streams with hand-computed words, addresses and flag timing.
module tb_upg_word_assembler;
    logic clk = 1'b0;
    logic rst, rx_vld, wen, done, err;
    logic [7:0] rx_dat;
    logic [13:0] adr;
    logic [31:0] dat;
    int checks = 0, failures = 0, nwr = 0;

    upg_word_assembler #(.ADDR_W(14), .TIMEOUT_CYCLES(16)) dut (
        .upg_clk_i(clk), .upg_rst_i(rst), .rx_dat_i(rx_dat), .rx_vld_i(rx_vld),
        .upg_wen_o(wen), .upg_adr_o(adr), .upg_dat_o(dat),
        .upg_done_o(done), .upg_err_o(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (wen) nwr <= nwr + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_dat = b;
        rx_vld = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx_vld = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_vld = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nwr = 0;
    endtask

    initial begin
        rst = 1'b1; rx_vld = 1'b0; rx_dat = 8'h00;
        @(negedge clk);
        do_reset();
        check("rst_wen", 32'(wen), 0);
        check("rst_adr", 32'(adr), 0);
        check("rst_dat", dat, 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);

        // single word
        send(8'h01); send(8'h00); send(8'h78); send(8'h56); send(8'h34);
        check("w1_no_early_wen", 32'(wen), 0);
        send(8'h12);
        check("w1_wen", 32'(wen), 1);
        check("w1_adr", 32'(adr), 0);
        check("w1_dat", dat, 32'h12345678);
        check("w1_done_not_yet", 32'(done), 0);
        idle(1);
        check("w1_wen_pulse", 32'(wen), 0);
        check("w1_done", 32'(done), 1);
        check("w1_err", 32'(err), 0);

        // two words back-to-back, then trailing bytes
        do_reset();
        send(8'h02); send(8'h00); send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        check("w2a_wen", 32'(wen), 1);
        check("w2a_adr", 32'(adr), 0);
        check("w2a_dat", dat, 32'hDEADBEEF);
        send(8'h04);
        check("w2_gap_wen", 32'(wen), 0);
        check("w2_hold_dat", dat, 32'hDEADBEEF);
        send(8'h03); send(8'h02); send(8'h01);
        check("w2b_wen", 32'(wen), 1);
        check("w2b_adr", 32'(adr), 1);
        check("w2b_dat", dat, 32'h01020304);
        check("w2b_done_not_yet", 32'(done), 0);
        send(8'hAA);
        check("w2_done", 32'(done), 1);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        idle(2);
        check("w2_nwr", 32'(nwr), 2);
        check("w2_done_sticky", 32'(done), 1);

        // count zero
        do_reset();
        send(8'h00); send(8'h00);
        check("c0_err", 32'(err), 1);
        check("c0_done", 32'(done), 0);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        idle(2);
        check("c0_nwr", 32'(nwr), 0);
        check("c0_err_sticky", 32'(err), 1);

        // count 16385 is one past depth
        do_reset();
        send(8'h01); send(8'h40);
        check("c16385_err", 32'(err), 1);
        check("c16385_done", 32'(done), 0);

        // count 16384 is full depth, accepted
        do_reset();
        send(8'h00); send(8'h40);
        check("c16384_err", 32'(err), 0);
        send(8'hA1); send(8'hB2); send(8'hC3); send(8'hD4);
        check("c16384_wen", 32'(wen), 1);
        check("c16384_dat", dat, 32'hD4C3B2A1);
        idle(1);
        check("c16384_done", 32'(done), 0);
        check("c16384_nwr", 32'(nwr), 1);

        // reset mid-word, with a byte coincident with reset
        do_reset();
        send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
        rst = 1'b1;
        send(8'h01);
        rst = 1'b0;
        idle(1);
        check("mid_rst_done", 32'(done), 0);
        nwr = 0;
        send(8'h01); send(8'h00); send(8'h44); send(8'h33); send(8'h22); send(8'h11);
        check("mid_wen", 32'(wen), 1);
        check("mid_adr", 32'(adr), 0);
        check("mid_dat", dat, 32'h11223344);
        idle(1);
        check("mid_done", 32'(done), 1);
        check("mid_nwr", 32'(nwr), 1);

        // stalled stream
        do_reset();
        send(8'h01); send(8'h00); send(8'h55);
        idle(10);
        check("to_early_err", 32'(err), 0);
        idle(30);
`ifdef UPG_TIMEOUT_EN
        check("to_err", 32'(err), 1);
`else
        check("to_err", 32'(err), 0);
`endif
        check("to_done", 32'(done), 0);
        check("to_nwr", 32'(nwr), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/upg_word_assembler.md
# upg_word_assembler

Byte-to-word loader that sits directly upstream of the program ROM's UART-programming port. It receives a byte stream from the UART receiver, parses a 2-byte word-count header, and assembles little-endian 32-bit instruction words. It drives the ROM's write-enable, word-address and data inputs, then raises a sticky done flag that returns the ROM to normal fetch mode.

## Interface
- `ADDR_W`, 14: word-address width; the ROM depth is 2^ADDR_W words.
- `TIMEOUT_CYCLES`, 1000000: maximum idle cycles allowed between bytes once a load has started. Used only with `UPG_TIMEOUT_EN`.

- `upg_clk_i`  in  1  clock.
- `upg_rst_i`  in  1  synchronous, active-high reset.
- `rx_dat_i`  in  8  received byte.
- `rx_vld_i`  in  1  one-cycle strobe; `rx_dat_i` is valid in that cycle.
- `upg_wen_o`  out  1  one-cycle ROM write strobe.
- `upg_adr_o`  out  ADDR_W  word address for the write.
- `upg_dat_o`  out  32  word data for the write.
- `upg_done_o`  out  1  sticky; the load completed successfully.
- `upg_err_o`  out  1  sticky; the load aborted.

## Operation
- **Reset values:** state IDLE; `upg_wen_o`=0, `upg_adr_o`=0, `upg_dat_o`=0, `upg_done_o`=0, `upg_err_o`=0; byte index=0; word count=0.
- **IDLE:** the first byte is latched as count[7:0], then go to CNT_HI.
- **CNT_HI:** the byte is latched as count[15:8].
  - If the full count is 0 or greater than 2^ADDR_W, go to ERR.
  - Otherwise go to DATA with address=0 and byte index=0.
- **DATA:** each byte is placed at lane `byte_idx`, so byte 0 lands in [7:0] and byte 3 in [31:24].
  - `byte_idx` wraps 3→0.
  - On the 4th byte the assembled word is issued as a write.
  - After a write the address increments.
  - When the number of written words equals the count, go to DONE.
- **DONE:** `upg_done_o`=1. All input is ignored until reset.
- **ERR:** `upg_err_o`=1 and `upg_done_o` stays 0. All input is ignored until reset.
- **Width rules:**
  - The count is 16 bits; valid range is 1..2^ADDR_W.
  - The internal written-word counter is ADDR_W+1 bits, so a full-depth load of 16384 words terminates correctly.
  - `upg_adr_o` never wraps within a load.
- `upg_wen_o` is never asserted outside DATA.

## Timing
- All outputs are registered.
- **Write latency:** the 4th byte strobe at cycle t gives `upg_wen_o`=1 at t+1 only.
  - `upg_adr_o` and `upg_dat_o` hold the write values at t+1.
  - Both keep those values until the next write.
- **Back-to-back bytes:** `rx_vld_i` may be high on every cycle. A byte arriving at t+1 (the write cycle) is accepted into the next word with no loss.
- **Done timing:** `upg_done_o` rises at t+2, where t is the last byte's cycle, i.e. one cycle after the final write pulse.
- **Count error timing:** `upg_err_o` rises one cycle after the offending count-high byte.
- **Reset:** `upg_rst_i` during any state, including mid-word, returns to IDLE on the next edge.
  - Reset discards the partial word and clears done/err.
  - Reset has priority over a coincident `rx_vld_i`.
- A partial word left at end of stream is never written.

## Configuration
- **`UPG_TIMEOUT_EN` defined:**
  - An idle counter clears on every `rx_vld_i` and counts while in CNT_HI or DATA.
  - When it reaches TIMEOUT_CYCLES with no byte, the next state is ERR.
  - The counter is inactive in IDLE, DONE and ERR.
  - A byte arriving in the same cycle the limit is reached wins: it is accepted and no timeout occurs.
- **`UPG_TIMEOUT_EN` undefined:**
  - No counter is built.
  - CNT_HI and DATA wait indefinitely.
  - `upg_err_o` is set only by an invalid count.

## Test plan
- **Reset:** hold `upg_rst_i` for 2 cycles → all outputs 0; state IDLE.
- **Single-word load:** bytes 01 00 78 56 34 12 → one `upg_wen_o` pulse with adr=0, dat=32'h12345678; `upg_done_o`=1 on the following cycle.
- **Two words, back-to-back:** bytes 02 00 EF BE AD DE 04 03 02 01, one per cycle → writes adr0=32'hDEADBEEF and adr1=32'h01020304 on consecutive-word pulses; then done; later bytes produce no write.
- **Count zero:** bytes 00 00 → `upg_err_o`=1, done=0, no write. Repeat with count 16385 (01 40) → err. Repeat with count 16384 (00 40) → accepted.
- **Reset mid-word:** count 1 plus 2 payload bytes, then reset, then a fresh single-word load → only the fresh word is written at adr=0.
- **Timeout (`UPG_TIMEOUT_EN`, TIMEOUT_CYCLES=16):** stop the stream after count plus 1 data byte → `upg_err_o`=1 after 16 idle cycles. Without the macro, the same stream leaves err=0 indefinitely.
